rvvi_frame_arbiter: RTL

RVVI_FRAME_ARBITER -- requirements
Module: rvvi_frame_arbiter

---
 rtl/rvvi_frame_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/rvvi_frame_arbiter.sv
// rtl/rvvi_frame_arbiter.sv - round-robin frame arbiter merging NUM_SRC write-data sources
// onto one AXI4 W channel, with burst truncation and a programmable inter-frame gap.
module rvvi_frame_arbiter #(
  parameter int NUM_SRC         = 2,
  parameter int MAX_BURST_WORDS = 256
) (
  input  logic                   m_axi_aclk,
  input  logic                   m_axi_aresetn,
  input  logic [NUM_SRC*32-1:0]  SrcWdata,
  input  logic [NUM_SRC*4-1:0]   SrcWstrb,
  input  logic [NUM_SRC-1:0]     SrcWlast,
  input  logic [NUM_SRC-1:0]     SrcWvalid,
  output logic [NUM_SRC-1:0]     SrcWready,
  output logic [31:0]            RvviAxiWdata,
  output logic [3:0]             RvviAxiWstrb,
  output logic                   RvviAxiWlast,
  output logic                   RvviAxiWvalid,
  input  logic                   RvviAxiWready,
  input  logic [31:0]            InterFrameGap,
  output logic [NUM_SRC-1:0]     Grant,
  output logic [31:0]            FrameCount,
  output logic                   Overrun
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW = ($clog2(MAX_BURST_WORDS) > 10) ? $clog2(MAX_BURST_WORDS) : 10;
  localparam logic [CW-1:0] LastBeat = CW'(MAX_BURST_WORDS - 1);

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  state_t         state, stateNext;
  logic [IW-1:0]  grantIdx, lastGrant, winIdx, candIdx;
  logic           winFound;
  logic [CW-1:0]  beatCnt;
  logic [31:0]    gapCnt;
  logic [31:0]    selData;
  logic [3:0]     selStrb;
  logic           selValid, selLast, inXfer, beat, frameEnd;

  // Search starts just after the source that completed the previous frame
  always_comb begin
    winIdx   = '0;
    winFound = 1'b0;
    candIdx  = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      candIdx = IW'((int'(lastGrant) + k) % NUM_SRC);
      if (!winFound && SrcWvalid[candIdx]) begin
        winFound = 1'b1;
        winIdx   = candIdx;
      end
    end
  end

  always_comb begin
    selData  = '0;
    selStrb  = '0;
    selValid = 1'b0;
    selLast  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grantIdx == IW'(i)) begin
        selData  = SrcWdata[i*32 +: 32];
        selStrb  = SrcWstrb[i*4 +: 4];
        selValid = SrcWvalid[i];
        selLast  = SrcWlast[i];
      end
    end
  end

  always_comb begin
    inXfer        = (state == XFER);
    RvviAxiWdata  = inXfer ? selData : '0;
    RvviAxiWstrb  = inXfer ? selStrb : '0;
    RvviAxiWvalid = inXfer & selValid;
    RvviAxiWlast  = inXfer & (selLast | (beatCnt == LastBeat));
    SrcWready     = inXfer ? (Grant & {NUM_SRC{RvviAxiWready}}) : '0;
    beat          = RvviAxiWvalid & RvviAxiWready;
    frameEnd      = beat & RvviAxiWlast;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (winFound) stateNext = XFER;
      XFER:    if (frameEnd) stateNext = (InterFrameGap != 32'd0) ? GAP : IDLE;
      GAP:     if (gapCnt <= 32'd1) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      state      <= IDLE;
      Grant      <= '0;
      grantIdx   <= '0;
      lastGrant  <= IW'(NUM_SRC - 1);
      beatCnt    <= '0;
      gapCnt     <= '0;
      FrameCount <= '0;
      Overrun    <= 1'b0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (winFound) begin
            grantIdx <= winIdx;
            Grant    <= NUM_SRC'(1) << winIdx;
            beatCnt  <= '0;
          end
        end
        XFER: begin
          if (beat) beatCnt <= beatCnt + 1'b1;
          // A truncated frame leaves the source mid-stream; its tail re-arbitrates later
          if (frameEnd) begin
            Grant      <= '0;
            lastGrant  <= grantIdx;
            FrameCount <= FrameCount + 32'd1;
            gapCnt     <= InterFrameGap;
            if (!selLast) Overrun <= 1'b1;
          end
        end
        GAP:     gapCnt <= gapCnt - 32'd1;
        default: ;
      endcase
    end
  end

endmodule
